// File: rtl/change_payout.sv
// change_payout: greedy largest-first note dispenser with per-denomination
// stock, per-request tally and unpaid-remainder reporting.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_amount/req_ready  change request handshake (ready in IDLE)
//   refill_en/refill_denom/refill_count  stock top-up, honoured in IDLE only
//   note_valid/note_denom/note_ack  one note per handshake
//   busy, done                    status; done is a one-cycle end pulse
//   short_amount                  unpaid remainder of the last request
//   tally_*                       notes paid in the current/last request
//   stock_*                       current stock per denomination
//   fault                         sticky ack-timeout flag
//
// Denomination codes: 0=5, 1=10, 2=20, 3=50, 4=100 (5-7 invalid).
// Optional macro PAYOUT_TIMEOUT_EN: abort a note after TIMEOUT_CYCLES
// cycles without note_ack and set the sticky fault flag. Without it the
// block waits for note_ack indefinitely and fault is tied low.

module change_payout #(
    parameter int AMT_W          = 32,
    parameter int CNT_W          = 8,
    parameter int INIT_CNT       = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             refill_en,
    input  logic [2:0]       refill_denom,
    input  logic [CNT_W-1:0] refill_count,
    output logic             note_valid,
    output logic [2:0]       note_denom,
    input  logic             note_ack,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] short_amount,
    output logic [CNT_W-1:0] tally_5,
    output logic [CNT_W-1:0] tally_10,
    output logic [CNT_W-1:0] tally_20,
    output logic [CNT_W-1:0] tally_50,
    output logic [CNT_W-1:0] tally_100,
    output logic [CNT_W-1:0] stock_5,
    output logic [CNT_W-1:0] stock_10,
    output logic [CNT_W-1:0] stock_20,
    output logic [CNT_W-1:0] stock_50,
    output logic [CNT_W-1:0] stock_100,
    output logic             fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam int NDEN = 5;

    // Note value for a denomination code, zero-extended to AMT_W.
    function automatic logic [AMT_W-1:0] f_val(input logic [2:0] c);
        logic [AMT_W-1:0] v;
        v = '0;
        case (c)
            3'd0:    v = AMT_W'(5);
            3'd1:    v = AMT_W'(10);
            3'd2:    v = AMT_W'(20);
            3'd3:    v = AMT_W'(50);
            3'd4:    v = AMT_W'(100);
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t           r_state;
    logic [AMT_W-1:0] r_rem;
    logic [AMT_W-1:0] r_short;
    logic [2:0]       r_denom;
    logic             r_note_valid;
    logic             r_done;
    logic [CNT_W-1:0] r_stock [NDEN];
    logic [CNT_W-1:0] r_tally [NDEN];

    logic             w_found;
    logic [2:0]       w_code;
    logic             w_refill_ok;
    logic [CNT_W-1:0] w_refill_cur;
    logic [CNT_W:0]   w_refill_sum;
    logic [CNT_W-1:0] w_refill_new;

    // Ascending scan: the last hit is the largest payable denomination.
    always_comb begin
        w_found = 1'b0;
        w_code  = 3'd0;
        for (int i = 0; i < NDEN; i++) begin
            if (f_val(3'(i)) <= r_rem && r_stock[i] != '0) begin
                w_found = 1'b1;
                w_code  = 3'(i);
            end
        end
    end

    always_comb begin
        w_refill_ok  = refill_en && (refill_denom < 3'd5);
        w_refill_cur = '0;
        for (int i = 0; i < NDEN; i++) begin
            if (refill_denom == 3'(i)) begin
                w_refill_cur = r_stock[i];
            end
        end
        w_refill_sum = {1'b0, w_refill_cur} + {1'b0, refill_count};
        // Carry out means the add overflowed: clamp to full scale.
        w_refill_new = w_refill_sum[CNT_W] ? '1 : w_refill_sum[CNT_W-1:0];
    end

`ifdef PAYOUT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_fault;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rem        <= '0;
            r_short      <= '0;
            r_denom      <= 3'd0;
            r_note_valid <= 1'b0;
            r_done       <= 1'b0;
            for (int i = 0; i < NDEN; i++) begin
                r_stock[i] <= CNT_W'(INIT_CNT);
                r_tally[i] <= '0;
            end
`ifdef PAYOUT_TIMEOUT_EN
            r_tmo        <= '0;
            r_fault      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_refill_ok) begin
                        r_stock[refill_denom] <= w_refill_new;
                    end
                    if (req_valid) begin
                        r_rem   <= req_amount;
                        r_short <= '0;
                        for (int i = 0; i < NDEN; i++) begin
                            r_tally[i] <= '0;
                        end
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_found) begin
                        r_denom      <= w_code;
                        r_note_valid <= 1'b1;
                        r_state      <= S_ISSUE;
`ifdef PAYOUT_TIMEOUT_EN
                        r_tmo        <= '0;
`endif
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (note_ack) begin
                        // SELECT only picks stocked notes, so no underflow.
                        r_rem <= r_rem - f_val(r_denom);
                        r_stock[r_denom] <= r_stock[r_denom] - CNT_W'(1);
                        if (r_tally[r_denom] != '1) begin
                            r_tally[r_denom] <= r_tally[r_denom] + CNT_W'(1);
                        end
                        r_note_valid <= 1'b0;
                        r_state      <= S_SELECT;
                    end
`ifdef PAYOUT_TIMEOUT_EN
                    else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_note_valid <= 1'b0;
                        r_done       <= 1'b1;
                        r_fault      <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_short <= r_rem;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign note_valid   = r_note_valid;
    assign note_denom   = r_denom;
    assign done         = r_done;
    assign short_amount = r_short;

    assign tally_5   = r_tally[0];
    assign tally_10  = r_tally[1];
    assign tally_20  = r_tally[2];
    assign tally_50  = r_tally[3];
    assign tally_100 = r_tally[4];

    assign stock_5   = r_stock[0];
    assign stock_10  = r_stock[1];
    assign stock_20  = r_stock[2];
    assign stock_50  = r_stock[3];
    assign stock_100 = r_stock[4];

`ifdef PAYOUT_TIMEOUT_EN
    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_change_payout.sv
// tb_change_payout: table-driven payout vectors plus hand-written
// sequences for reset, refills, mid-payout reset and ack timeout.

module tb_change_payout;

    localparam int AW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] req_amount;
    logic          req_ready;
    logic          refill_en;
    logic [2:0]    refill_denom;
    logic [CW-1:0] refill_count;
    logic          note_valid;
    logic [2:0]    note_denom;
    logic          note_ack;
    logic          busy;
    logic          done;
    logic [AW-1:0] short_amount;
    logic [CW-1:0] tally_5, tally_10, tally_20, tally_50, tally_100;
    logic [CW-1:0] stock_5, stock_10, stock_20, stock_50, stock_100;
    logic          fault;

    always #5 clk = ~clk;

    change_payout #(
        .AMT_W(AW), .CNT_W(CW), .INIT_CNT(10), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready),
        .refill_en(refill_en), .refill_denom(refill_denom),
        .refill_count(refill_count),
        .note_valid(note_valid), .note_denom(note_denom),
        .note_ack(note_ack),
        .busy(busy), .done(done), .short_amount(short_amount),
        .tally_5(tally_5), .tally_10(tally_10), .tally_20(tally_20),
        .tally_50(tally_50), .tally_100(tally_100),
        .stock_5(stock_5), .stock_10(stock_10), .stock_20(stock_20),
        .stock_50(stock_50), .stock_100(stock_100),
        .fault(fault)
    );

    logic [CW-1:0] tl [5];
    logic [CW-1:0] sk [5];
    assign tl[0] = tally_5;
    assign tl[1] = tally_10;
    assign tl[2] = tally_20;
    assign tl[3] = tally_50;
    assign tl[4] = tally_100;
    assign sk[0] = stock_5;
    assign sk[1] = stock_10;
    assign sk[2] = stock_20;
    assign sk[3] = stock_50;
    assign sk[4] = stock_100;

    typedef struct packed {
        logic [31:0]     amt;
        logic [7:0]      dly;
        logic            rf_en;
        logic [2:0]      rf_code;
        logic [7:0]      rf_cnt;
        logic            brf;
        logic [31:0]     shrt;
        logic [4:0][7:0] tal;
        logic [4:0][7:0] stk;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Tally and stock arguments are in 5,10,20,50,100 order.
    task automatic add(input int amt, input int dly, input bit rf_en,
                       input int rf_code, input int rf_cnt, input bit brf,
                       input int shrt,
                       input int t0, input int t1, input int t2,
                       input int t3, input int t4,
                       input int s0, input int s1, input int s2,
                       input int s3, input int s4);
        vec_t v;
        v.amt     = 32'(amt);
        v.dly     = 8'(dly);
        v.rf_en   = rf_en;
        v.rf_code = 3'(rf_code);
        v.rf_cnt  = 8'(rf_cnt);
        v.brf     = brf;
        v.shrt    = 32'(shrt);
        v.tal[0] = 8'(t0); v.tal[1] = 8'(t1); v.tal[2] = 8'(t2);
        v.tal[3] = 8'(t3); v.tal[4] = 8'(t4);
        v.stk[0] = 8'(s0); v.stk[1] = 8'(s1); v.stk[2] = 8'(s2);
        v.stk[3] = 8'(s3); v.stk[4] = 8'(s4);
        vq.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   k;
        int   w;
        int   done_k;
        int   prev;
        int   total;
        int   cnt [5];
        logic [2:0] cur;
        bit   seen_done;
        bit   mono;
        bit   stable;
        string tag;
        tag = $sformatf("v%0d", idx);
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        seen_done = 1'b0;
        mono = 1'b1;
        stable = 1'b1;
        prev = 5;
        done_k = 0;
        cur = 3'd0;
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_amount   = v.amt;
        refill_en    = v.rf_en;
        refill_denom = v.rf_code;
        refill_count = v.rf_cnt;
        cyc();
        req_valid = 1'b0;
        refill_en = 1'b0;
        k = 1;
        w = 0;
        while (!seen_done && k < 400) begin
            if (done) begin
                seen_done = 1'b1;
                done_k = k;
            end else if (note_valid) begin
                if (w == 0) begin
                    cur = note_denom;
                    if (int'(cur) < 5) cnt[cur]++;
                    if (int'(cur) > prev) mono = 1'b0;
                    prev = int'(cur);
                end else if (note_denom !== cur) begin
                    stable = 1'b0;
                end
                if (w >= int'(v.dly)) begin
                    note_ack = 1'b1;
                    w = 0;
                end else begin
                    w++;
                    if (v.brf) begin
                        refill_en    = 1'b1;
                        refill_denom = 3'd0;
                        refill_count = 8'd4;
                    end
                end
            end
            if (!seen_done) begin
                cyc();
                note_ack  = 1'b0;
                refill_en = 1'b0;
                k++;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen_done), 64'd1);
        chk({tag, "_order"}, 64'(mono), 64'd1);
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        total = 0;
        for (int i = 0; i < 5; i++) total += int'(v.tal[i]);
        if (total == 0) chk({tag, "_done_lat"}, 64'(done_k), 64'd2);
        cyc();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(req_ready), 64'd1);
        chk({tag, "_short"}, 64'(short_amount), 64'(v.shrt));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_notes%0d", tag, i), 64'(cnt[i]),
                64'(v.tal[i]));
            chk($sformatf("%s_tally%0d", tag, i), 64'(tl[i]),
                64'(v.tal[i]));
            chk($sformatf("%s_stock%0d", tag, i), 64'(sk[i]),
                64'(v.stk[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_amount   = '0;
        refill_en    = 1'b0;
        refill_denom = 3'd0;
        refill_count = '0;
        note_ack     = 1'b0;

        // amt dly rf rfc rfn brf short | tally 5..100 | stock 5..100
        add(185, 0, 0, 0, 0, 0,   0, 1,1,1,1,1, 9,9,9,9,9);
        add(900, 0, 0, 0, 0, 0,   0, 0,0,0,0,9, 9,9,9,9,0);
        add(450, 1, 0, 0, 0, 0,   0, 0,0,0,9,0, 9,9,9,0,0);
        add(60,  0, 0, 0, 0, 0,   0, 0,0,3,0,0, 9,9,6,0,0);
        add(7,   0, 0, 0, 0, 0,   2, 1,0,0,0,0, 8,9,6,0,0);
        add(0,   0, 0, 0, 0, 0,   0, 0,0,0,0,0, 8,9,6,0,0);
        add(35,  3, 0, 0, 0, 0,   0, 1,1,1,0,0, 7,8,5,0,0);
        add(1000,0, 0, 0, 0, 0, 785, 7,8,5,0,0, 0,0,0,0,0);
        add(15,  0, 0, 0, 0, 0,  15, 0,0,0,0,0, 0,0,0,0,0);
        add(5,   0, 1, 0, 2, 0,   0, 1,0,0,0,0, 1,0,0,0,0);
        add(5,   3, 0, 0, 0, 1,   0, 1,0,0,0,0, 0,0,0,0,0);
        add(0,   0, 1, 5, 9, 0,   0, 0,0,0,0,0, 0,0,0,0,0);

        // Reset held for two edges.
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_stock%0d", i), 64'(sk[i]), 64'd10);
            chk($sformatf("rst_tally%0d", i), 64'(tl[i]), 64'd0);
        end
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_nv", 64'(note_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_short", 64'(short_amount), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        rst = 1'b0;
        cyc();

        foreach (vq[i]) run_vec(vq[i], i);

        // Idle refills with saturation and an invalid code.
        refill_en = 1'b1; refill_denom = 3'd1; refill_count = 8'd10;
        cyc();
        refill_en = 1'b0;
        chk("rf_10", 64'(stock_10), 64'd10);
        refill_en = 1'b1; refill_count = 8'd250;
        cyc();
        refill_en = 1'b0;
        chk("rf_sat", 64'(stock_10), 64'd255);
        refill_en = 1'b1; refill_count = 8'd1;
        cyc();
        refill_en = 1'b0;
        chk("rf_sat_hold", 64'(stock_10), 64'd255);
        refill_en = 1'b1; refill_denom = 3'd7; refill_count = 8'd3;
        cyc();
        refill_en = 1'b0;
        chk("rf_bad_code", 64'(stock_5), 64'd0);

        // Reset while a note is pending drops it uncounted.
        do_reset();
        req_valid = 1'b1; req_amount = 32'd100;
        cyc();
        req_valid = 1'b0;
        n = 0;
        while (!note_valid && n < 10) begin
            cyc();
            n++;
        end
        chk("mid_nv_seen", 64'(note_valid), 64'd1);
        chk("mid_denom", 64'(note_denom), 64'd4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_stock100", 64'(stock_100), 64'd10);
        chk("mid_tally100", 64'(tally_100), 64'd0);
        chk("mid_nv", 64'(note_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);

`ifdef PAYOUT_TIMEOUT_EN
        // Never ack: note_valid holds 16 cycles then the block gives up.
        cyc();
        req_valid = 1'b1; req_amount = 32'd100;
        cyc();
        req_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (note_valid) n++;
            cyc();
        end
        chk("tmo_nv_cycles", 64'(n), 64'd16);
        chk("tmo_done", 64'(done), 64'd1);
        chk("tmo_nv_low", 64'(note_valid), 64'd0);
        cyc();
        chk("tmo_short", 64'(short_amount), 64'd100);
        chk("tmo_fault", 64'(fault), 64'd1);
        chk("tmo_stock100", 64'(stock_100), 64'd10);
        chk("tmo_tally100", 64'(tally_100), 64'd0);
        cyc();
        cyc();
        chk("tmo_fault_sticky", 64'(fault), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("tmo_fault_clr", 64'(fault), 64'd0);
`else
        chk("fault_tied", 64'(fault), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
